writeback_unit: RTL and testbench

Writeback stage of the pipeline: merges single-cycle ALU results and variable-latency LSU load responses into the register file's single write port. It drives `wr_en`/`wr_addr`/`wr_data`, buffers load responses in a small FIFO, and performs load byte/half extraction. It also keeps a pending-load scoreboard so the hazard logic can stall on registers with loads still in flight.

---
 rtl/wb_pkg.sv | 41 ++++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/writeback_unit.sv | 126 ++++++++++++
 tb/tb_writeback_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: data width, load funct3
// codes, the buffered load-response entry and load byte/half extraction.
package wb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [2:0]      funct3,
                                                   input logic [1:0]      addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] res;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   res = {{(XLEN-8){b[7]}}, b};
      F3_LH:   res = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  res = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of load-response entries with wrap-around pointers and an
// occupancy counter; full/empty are derived from the counter.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t pop_entry,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign pop_entry = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  // A full FIFO still accepts a push when an entry leaves on the same edge.
  assign do_push   = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results and buffered load responses onto the
// single register-file write port and tracks registers with loads in flight.
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic            stall_o,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  import wb_pkg::*;

  wb_entry_t       push_entry, pop_entry;
  logic            fifo_full, fifo_empty, push, pop;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     pending_q, pending_d, set_mask, clr_mask;

  assign lsu_ready     = !fifo_full;
  assign push          = lsu_valid && lsu_ready;
  assign push_entry.rd   = lsu_rd;
  assign push_entry.data = load_extract(lsu_rdata, lsu_funct3, lsu_addr_lo);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .pop_entry  (pop_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Write-source priority: a full FIFO drains first, then ALU, then FIFO.
  always_comb begin
    pop       = 1'b0;
    stall_o   = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    if (fifo_full) begin
      pop       = 1'b1;
      stall_o   = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = pop_entry.rd;
      sel_data  = pop_entry.data;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = pop_entry.rd;
      sel_data  = pop_entry.data;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Write-port next state; x0 writes are consumed but never enabled.
  always_comb begin
    wr_en_d   = sel_valid && (sel_rd != 5'd0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  // Scoreboard next state: a new issue to the same rd outranks the pop clear.
  always_comb begin
    set_mask  = (ld_issue && (ld_issue_rd != 5'd0)) ? (32'd1 << ld_issue_rd) : 32'd0;
    clr_mask  = pop ? (32'd1 << pop_entry.rd) : 32'd0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
      pending_q <= 32'd0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rs1_pending = pending_q[rs1_addr];
  assign rs2_pending = pending_q[rs2_addr];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_pending, rs2_pending, stall_o, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rdata(lsu_rdata), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .stall_o(stall_o), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] rdata;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_issue_rd = 5'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_rdata = 32'd0;
    lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
  endtask

  // Reference extraction from the load-type rules, by shift and mask.
  function automatic logic [31:0] ref_extract(input logic [31:0] rdata, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [31:0] b, h;
    b = (rdata >> (8 * int'(lo))) & 32'h0000_00FF;
    h = (rdata >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b[7]  ? (b | 32'hFFFF_FF00) : b);
      3'b001:  return (h[15] ? (h | 32'hFFFF_0000) : h);
      3'b100:  return b;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  vec_t vecs [11];

  // Random-phase model state.
  ent_t        q[$];
  logic        pend [32];
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    rst_n = 1'b0;

    vecs[0]  = '{"alu_rd5",  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'd0, 3'b000, 2'd0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1]  = '{"alu_rd0",  1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0,  32'd0, 3'b000, 2'd0, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{"lb_lo1",   1'b0, 5'd0, 32'd0, 1'b1, 5'd9,  32'h8070F0A5, 3'b000, 2'd1, 1'b1, 5'd9,  32'hFFFFFFF0};
    vecs[3]  = '{"lbu_lo0",  1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h8070F0A5, 3'b100, 2'd0, 1'b1, 5'd10, 32'h000000A5};
    vecs[4]  = '{"lh_lo2",   1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h8070F0A5, 3'b001, 2'd2, 1'b1, 5'd11, 32'hFFFF8070};
    vecs[5]  = '{"lhu_lo2",  1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h8070F0A5, 3'b101, 2'd2, 1'b1, 5'd12, 32'h00008070};
    vecs[6]  = '{"lw",       1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h8070F0A5, 3'b010, 2'd3, 1'b1, 5'd13, 32'h8070F0A5};
    vecs[7]  = '{"f3_111",   1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h8070F0A5, 3'b111, 2'd1, 1'b1, 5'd14, 32'h8070F0A5};
    vecs[8]  = '{"lh_lo3",   1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h8070F0A5, 3'b001, 2'd3, 1'b1, 5'd15, 32'hFFFF8070};
    vecs[9]  = '{"lb_lo3",   1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h8070F0A5, 3'b000, 2'd3, 1'b1, 5'd16, 32'hFFFFFF80};
    vecs[10] = '{"ld_rd0",   1'b0, 5'd0, 32'd0, 1'b1, 5'd0,  32'h11112222, 3'b010, 2'd0, 1'b0, 5'd16, 32'hFFFFFF80};

    // Reset state.
    step(); step();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rs1_pending", 32'(rs1_pending), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
      lsu_valid = vecs[i].ld_v; lsu_rd = vecs[i].ld_rd; lsu_rdata = vecs[i].rdata;
      lsu_funct3 = vecs[i].f3; lsu_addr_lo = vecs[i].lo;
      step();
      idle();
      if (vecs[i].ld_v) step();
      chk({vecs[i].name, "_en"}, 32'(wr_en), 32'(vecs[i].exp_en));
      chk({vecs[i].name, "_addr"}, 32'(wr_addr), 32'(vecs[i].exp_addr));
      chk({vecs[i].name, "_data"}, wr_data, vecs[i].exp_data);
      step();
    end

    // Contention: ALU at edge k, load at edge k+1.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_rdata = 32'h44; lsu_funct3 = 3'b010;
    step();
    idle();
    chk("cont_alu_en", 32'(wr_en), 32'd1);
    chk("cont_alu_addr", 32'(wr_addr), 32'd3);
    chk("cont_alu_data", wr_data, 32'h11);
    step();
    chk("cont_ld_en", 32'(wr_en), 32'd1);
    chk("cont_ld_addr", 32'(wr_addr), 32'd4);
    chk("cont_ld_data", wr_data, 32'h44);
    step();

    // Backpressure: continuous ALU while two loads arrive.
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_rdata = 32'h21; lsu_funct3 = 3'b010;
    step();
    chk("bp_w1_addr", 32'(wr_addr), 32'd20);
    alu_rd = 5'd22; alu_data = 32'hA2; lsu_rd = 5'd23; lsu_rdata = 32'h23;
    step();
    chk("bp_w2_addr", 32'(wr_addr), 32'd22);
    chk("bp_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("bp_stall", 32'(stall_o), 32'd1);
    lsu_valid = 1'b0; alu_rd = 5'd24; alu_data = 32'hA3;
    step();
    chk("bp_pop_addr", 32'(wr_addr), 32'd21);
    chk("bp_pop_data", wr_data, 32'h21);
    chk("bp_unstall", 32'(stall_o), 32'd0);
    step();
    chk("bp_held_addr", 32'(wr_addr), 32'd24);
    chk("bp_held_data", wr_data, 32'hA3);
    alu_valid = 1'b0;
    step();
    chk("bp_drain_addr", 32'(wr_addr), 32'd23);
    chk("bp_drain_en", 32'(wr_en), 32'd1);
    idle();
    step();

    // Scoreboard: set, hold through pop with same-edge re-issue, then clear.
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    chk("sb_set", 32'(rs1_pending), 32'd1);
    chk("sb_other", 32'(rs2_pending), 32'd0);
    ld_issue = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = 32'h77; lsu_funct3 = 3'b010;
    step();
    chk("sb_push_hold", 32'(rs1_pending), 32'd1);
    lsu_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    chk("sb_setwins", 32'(rs1_pending), 32'd1);
    chk("sb_pop1_addr", 32'(wr_addr), 32'd7);
    ld_issue = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = 32'h78;
    step();
    lsu_valid = 1'b0;
    chk("sb_push2_hold", 32'(rs1_pending), 32'd1);
    step();
    chk("sb_clear", 32'(rs1_pending), 32'd0);
    chk("sb_pop2_data", wr_data, 32'h78);
    rs1_addr = 5'd0; ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    chk("sb_x0", 32'(rs1_pending), 32'd0);
    idle();

    // Reset mid-operation with two buffered loads and pending[7].
    rs1_addr = 5'd7;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd30; lsu_rdata = 32'h30; lsu_funct3 = 3'b010;
    step();
    ld_issue = 1'b0; alu_rd = 5'd2; alu_data = 32'h2; lsu_rd = 5'd31;
    step();
    idle();
    chk("mid_full", 32'(stall_o), 32'd1);
    chk("mid_pend", 32'(rs1_pending), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_ready", 32'(lsu_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_pend", 32'(rs1_pending), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_write", 32'(wr_en), 32'd0);
      chk("post_rst_ready", 32'(lsu_ready), 32'd1);
    end

    // Randomized run against the queue model (starts from a fresh reset).
    rst_n = 1'b0;
    step();
    @(negedge clk) rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      int   sz;
      logic accept, have;
      ent_t e, src;
      alu_valid   = ($urandom_range(0, 99) < 50);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 99) < 30);
      ld_issue_rd = 5'($urandom_range(0, 31));
      lsu_valid   = ($urandom_range(0, 99) < 55);
      lsu_rd      = 5'($urandom_range(0, 31));
      lsu_rdata   = $urandom;
      lsu_funct3  = 3'($urandom_range(0, 7));
      lsu_addr_lo = 2'($urandom_range(0, 3));
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));

      sz = q.size();
      accept = lsu_valid && (sz < DEPTH);
      have = 1'b0;
      src = '{5'd0, 32'd0};
      if (sz == DEPTH || (!alu_valid && sz > 0)) begin
        e = q.pop_front();
        src = e; have = 1'b1;
        pend[e.rd] = 1'b0;
      end else if (alu_valid) begin
        src = '{alu_rd, alu_data}; have = 1'b1;
      end
      m_en = have && (src.rd != 5'd0);
      if (m_en) begin
        m_addr = src.rd; m_data = src.data;
      end
      if (ld_issue && ld_issue_rd != 5'd0) pend[ld_issue_rd] = 1'b1;
      if (accept) q.push_back('{lsu_rd, ref_extract(lsu_rdata, lsu_funct3, lsu_addr_lo)});

      step();
      chk("rnd_wr_en", 32'(wr_en), 32'(m_en));
      chk("rnd_wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("rnd_wr_data", wr_data, m_data);
      chk("rnd_lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
      chk("rnd_stall", 32'(stall_o), 32'(q.size() == DEPTH));
      chk("rnd_rs1_pend", 32'(rs1_pending), 32'(pend[rs1_addr]));
      chk("rnd_rs2_pend", 32'(rs2_pending), 32'(pend[rs2_addr]));
      if (n_err > 20) break;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
